// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle RV32I datapath.
// Define CTL_TIMEOUT_EN to trap on handshakes lasting MEM_TIMEOUT cycles.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 255,
   parameter int STATE_W     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               alu_src_1,
   output logic               alu_src_2,
   output logic               out_sel,
   output logic               branch,
   output logic [1:0]         alu_op,
   output logic               illegal,
   output logic               timeout,
   output logic [STATE_W-1:0] state_dbg
);

   localparam logic       CTL_ALU_SRC1_RS1 = 1'b0;
   localparam logic       CTL_ALU_SRC1_PC  = 1'b1;
   localparam logic       CTL_ALU_SRC2_RS2 = 1'b0;
   localparam logic       CTL_ALU_SRC2_IMM = 1'b1;
   localparam logic       CTL_OUT_ALU      = 1'b0;
   localparam logic       CTL_OUT_IMM      = 1'b1;
   localparam logic [1:0] CTL_ALU_ADD      = 2'd0;
   localparam logic [1:0] CTL_ALU_BRANCH   = 2'd1;
   localparam logic [1:0] CTL_ALU_OP       = 2'd2;
   localparam logic [1:0] CTL_ALU_OPIMM    = 2'd3;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   state_e     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;
   logic       wait_hit;

   logic is_load, is_store, is_branch, is_lui, is_jump;

   function automatic logic legal_op(input logic [6:0] op);
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_AUIPC,
         OPC_STORE, OPC_OP, OPC_LUI,
         OPC_BRANCH, OPC_JALR, OPC_JAL: legal_op = 1'b1;
         default:                       legal_op = 1'b0;
      endcase
   endfunction

   assign is_load   = (op_q == OPC_LOAD);
   assign is_store  = (op_q == OPC_STORE);
   assign is_branch = (op_q == OPC_BRANCH);
   assign is_lui    = (op_q == OPC_LUI);
   assign is_jump   = (op_q == OPC_JAL) || (op_q == OPC_JALR);

`ifdef CTL_TIMEOUT_EN
   logic [15:0] wait_q, wait_d;

   // Any cycle that is not a stalled handshake clears the count.
   always_comb begin
      wait_d = '0;
      if ((state_q == S_FETCH && !imem_ready) ||
          (state_q == S_MEM && !dmem_ready))
         wait_d = wait_q + 16'd1;
   end

   assign wait_hit = (wait_q == 16'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`else
   assign wait_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (wait_hit) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (legal_op(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (is_load || is_store) state_d = S_MEM;
            else if (is_branch)      state_d = S_FETCH;
            else                     state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               state_d = is_load ? S_WB : S_FETCH;
            end else if (wait_hit) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = state_q;
      endcase
   end

   // Strobes come from state and op_q; only handshake pulses see ready.
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_1  = CTL_ALU_SRC1_RS1;
      alu_src_2  = CTL_ALU_SRC2_RS2;
      out_sel    = CTL_OUT_ALU;
      branch     = 1'b0;
      alu_op     = CTL_ALU_ADD;
      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_write = imem_ready;
         end
         S_EXEC: begin
            case (op_q)
               OPC_OP_IMM: begin
                  alu_src_2 = CTL_ALU_SRC2_IMM;
                  alu_op    = CTL_ALU_OPIMM;
               end
               OPC_AUIPC, OPC_JAL: begin
                  alu_src_1 = CTL_ALU_SRC1_PC;
                  alu_src_2 = CTL_ALU_SRC2_IMM;
               end
               OPC_OP: alu_op = CTL_ALU_OP;
               OPC_LUI: begin
                  alu_src_2 = CTL_ALU_SRC2_IMM;
                  out_sel   = CTL_OUT_IMM;
               end
               OPC_BRANCH: begin
                  alu_op   = CTL_ALU_BRANCH;
                  branch   = 1'b1;
                  pc_write = 1'b1;
               end
               default: alu_src_2 = CTL_ALU_SRC2_IMM;
            endcase
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            mem_read  = is_load;
            mem_write = is_store;
            pc_write  = is_store && dmem_ready;
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = is_load;
            branch     = is_jump;
            out_sel    = is_lui ? CTL_OUT_IMM : CTL_OUT_ALU;
         end
         default: ;
      endcase
   end

   assign illegal   = illegal_q;
   assign timeout   = timeout_q;
   assign state_dbg = STATE_W'(state_q);

endmodule
